// File: rtl/icache.sv
// Direct-mapped read-only I-cache with 4-word lines. Hits are combinational (0 cycles); a miss fills the line over mem_req/mem_ack.
// proc_inst_valid stays low for the whole fill. Each word request is held until memory acks, so a slow memory just lengthens the fill.
module icache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc_addr,
  input  logic [1:0]  proc_command,
  output logic [31:0] proc_inst,
  output logic        proc_inst_valid,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IW-1:0] index;
    logic [1:0]    word;
    logic [1:0]    byte_off;
  } addr_t;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, state_nxt;
  addr_t           req;
  logic [31:0]     data_q [LINES][4];
  logic [TW-1:0]   tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   fill_tag;
  logic [IW-1:0]   fill_index;
  logic [1:0]      word_cnt;
  logic            abort;
  logic            lookup_hit;
  logic            start_fill;
  logic            fill_ack;
  logic            fill_done;

  assign req = addr_t'(proc_addr);

  assign lookup_hit = (proc_command == BUS_LOAD) && valid_q[req.index]
                      && (tag_q[req.index] == req.tag);

  assign proc_inst       = data_q[req.index][req.word];
  assign proc_inst_valid = (state == IDLE) && lookup_hit;

  // Request side comes only from registered state so acks cannot disturb it.
  assign mem_req  = (state == FILL);
  assign mem_addr = (state == FILL) ? {fill_tag, fill_index, word_cnt, 2'b00} : 32'h0;
  assign fill_ack = (state == FILL) && mem_ack;

  always_comb begin
    state_nxt  = state;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if ((proc_command == BUS_LOAD) && !lookup_hit) begin
          state_nxt  = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        if (mem_ack && (word_cnt == 2'd3)) begin
          state_nxt = IDLE;
          fill_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      word_cnt   <= 2'd0;
      abort      <= 1'b0;
      miss_count <= 16'h0;
    end else begin
      state <= state_nxt;

      if (start_fill)
        word_cnt <= 2'd0;
      else if (fill_ack)
        word_cnt <= word_cnt + 2'd1;

      if (start_fill && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;

      if (fill_done)
        abort <= 1'b0;
      else if ((state == FILL) && invalidate)
        abort <= 1'b1;

      // Victim is dropped as the fill starts so a half-written line never hits.
      if (invalidate)
        valid_q <= '0;
      else begin
        if (start_fill)
          valid_q[req.index] <= 1'b0;
        if (fill_done && !abort)
          valid_q[fill_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_fill) begin
      fill_tag   <= req.tag;
      fill_index <= req.index;
    end
    if (fill_ack)
      data_q[fill_index][word_cnt] <= mem_rdata;
    if (fill_done)
      tag_q[fill_index] <= fill_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: memory model returns {16'hC0DE, addr[15:0]} for each word address.
module tb_icache;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] proc_addr = 32'h0;
  logic [1:0]  proc_command = BUS_NONE;
  logic [31:0] proc_inst;
  logic        proc_inst_valid;
  logic        invalidate = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ack_addrs [$];
  logic [31:0] cyc_addrs [$];
  int          fill_cycles;
  int          fill_vld_seen;
  logic [15:0] first_mc;

  icache #(.LINES(16)) dut (
    .clk(clk), .rst(rst),
    .proc_addr(proc_addr), .proc_command(proc_command),
    .proc_inst(proc_inst), .proc_inst_valid(proc_inst_valid),
    .invalidate(invalidate),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Runs a fill from the cycle after the miss until mem_req drops; ack on every gap-th FILL cycle.
  task automatic fill_run(input int gap, input int inv_at, input int redir_at, input logic [31:0] redir_addr);
    int  cyc;
    bit  done;
    ack_addrs.delete();
    cyc_addrs.delete();
    fill_cycles   = 0;
    fill_vld_seen = 0;
    first_mc      = 16'h0;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      mem_ack    = 1'b0;
      invalidate = 1'b0;
      @(negedge clk);
      if (!mem_req) begin
        done = 1'b1;
      end else begin
        cyc++;
        fill_cycles = cyc;
        if (cyc == 1) first_mc = miss_count;
        if (proc_inst_valid) fill_vld_seen++;
        cyc_addrs.push_back(mem_addr);
        if (cyc == redir_at) proc_addr = redir_addr;
        if (cyc == inv_at) invalidate = 1'b1;
        if ((cyc % gap) == 0) begin
          mem_ack = 1'b1;
          ack_addrs.push_back(mem_addr);
        end
        if (cyc > 200) begin
          mem_ack = 1'b0;
          done    = 1'b1;
        end
      end
    end
  endtask

  task automatic present(input logic [1:0] cmd, input logic [31:0] addr);
    @(posedge clk); #1;
    proc_command = cmd;
    proc_addr    = addr;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %0b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); else n_pass++;
    n_checks++; if (miss_count !== 16'h0) $display("FAIL reset_miss_count: got %0d want 0", miss_count); else n_pass++;
    proc_command = BUS_LOAD;
    proc_addr    = 32'h40;
    #1;
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", proc_inst_valid); else n_pass++;
    proc_command = BUS_NONE;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_miss;
    logic [31:0] got;
    present(BUS_LOAD, 32'h40);
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL miss_c0_valid: got %0b want 0", proc_inst_valid); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL miss_c0_mem_req: got %0b want 0", mem_req); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    n_checks++; if (fill_cycles !== 4) $display("FAIL miss_fill_cycles: got %0d want 4", fill_cycles); else n_pass++;
    n_checks++; if (first_mc !== 16'd1) $display("FAIL miss_count_n1: got %0d want 1", first_mc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < ack_addrs.size()) ? ack_addrs[i] : 32'hFFFF_FFFF;
      n_checks++; if (got !== 32'h40 + 32'(4 * i)) $display("FAIL miss_addr_w%0d: got %h want %h", i, got, 32'h40 + 32'(4 * i)); else n_pass++;
    end
    n_checks++; if (proc_inst_valid !== 1'b1) $display("FAIL miss_n5_valid: got %0b want 1", proc_inst_valid); else n_pass++;
    n_checks++; if (proc_inst !== 32'hC0DE_0040) $display("FAIL miss_n5_inst: got %h want C0DE0040", proc_inst); else n_pass++;
    n_checks++; if (miss_count !== 16'd1) $display("FAIL miss_count_1: got %0d want 1", miss_count); else n_pass++;
  endtask

  task automatic test_seq_hits;
    logic [31:0] addrs [3] = '{32'h44, 32'h48, 32'h4C};
    logic [31:0] exps  [3] = '{32'hC0DE_0044, 32'hC0DE_0048, 32'hC0DE_004C};
    for (int i = 0; i < 3; i++) begin
      present(BUS_LOAD, addrs[i]);
      n_checks++; if (proc_inst_valid !== 1'b1) $display("FAIL seq_valid_%0d: got %0b want 1", i, proc_inst_valid); else n_pass++;
      n_checks++; if (proc_inst !== exps[i]) $display("FAIL seq_inst_%0d: got %h want %h", i, proc_inst, exps[i]); else n_pass++;
      n_checks++; if (mem_req !== 1'b0) $display("FAIL seq_mem_req_%0d: got %0b want 0", i, mem_req); else n_pass++;
    end
    // Idle command with a stray ack: no hit, no fill.
    present(BUS_NONE, 32'h40);
    mem_ack = 1'b1;
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL none_valid: got %0b want 0", proc_inst_valid); else n_pass++;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("FAIL none_mem_req: got %0b want 0", mem_req); else n_pass++;
    n_checks++; if (miss_count !== 16'd1) $display("FAIL none_miss_count: got %0d want 1", miss_count); else n_pass++;
  endtask

  task automatic test_conflict;
    logic [31:0] got;
    present(BUS_LOAD, 32'h140);
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL conf_miss_valid: got %0b want 0", proc_inst_valid); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      got = (i < ack_addrs.size()) ? ack_addrs[i] : 32'hFFFF_FFFF;
      n_checks++; if (got !== 32'h140 + 32'(4 * i)) $display("FAIL conf_addr_w%0d: got %h want %h", i, got, 32'h140 + 32'(4 * i)); else n_pass++;
    end
    n_checks++; if (proc_inst !== 32'hC0DE_0140 || proc_inst_valid !== 1'b1) $display("FAIL conf_hit: got %h/%0b want C0DE0140/1", proc_inst, proc_inst_valid); else n_pass++;
    present(BUS_LOAD, 32'h40);
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL conf_evict_valid: got %0b want 0", proc_inst_valid); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    n_checks++; if (fill_cycles !== 4) $display("FAIL conf_fill_cycles: got %0d want 4", fill_cycles); else n_pass++;
    n_checks++; if (proc_inst !== 32'hC0DE_0040 || proc_inst_valid !== 1'b1) $display("FAIL conf_refill_hit: got %h/%0b want C0DE0040/1", proc_inst, proc_inst_valid); else n_pass++;
    n_checks++; if (miss_count !== 16'd3) $display("FAIL conf_miss_count: got %0d want 3", miss_count); else n_pass++;
  endtask

  task automatic test_slow_ack;
    bit held_ok;
    logic [31:0] got;
    present(BUS_LOAD, 32'h238);
    fill_run(3, 0, 5, 32'h44);
    n_checks++; if (fill_cycles !== 12) $display("FAIL slow_fill_cycles: got %0d want 12", fill_cycles); else n_pass++;
    held_ok = (cyc_addrs.size() == 12);
    for (int k = 0; k < cyc_addrs.size() && k < 12; k++)
      if (cyc_addrs[k] !== 32'h230 + 32'(4 * (k / 3))) held_ok = 1'b0;
    n_checks++; if (!held_ok) $display("FAIL slow_addr_hold: got %0d cycles, address sequence wrong; want 230,234,238,23C x3 each", cyc_addrs.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < ack_addrs.size()) ? ack_addrs[i] : 32'hFFFF_FFFF;
      n_checks++; if (got !== 32'h230 + 32'(4 * i)) $display("FAIL slow_ack_w%0d: got %h want %h", i, got, 32'h230 + 32'(4 * i)); else n_pass++;
    end
    n_checks++; if (fill_vld_seen !== 0) $display("FAIL slow_valid_in_fill: got %0d cycles want 0", fill_vld_seen); else n_pass++;
    n_checks++; if (proc_inst !== 32'hC0DE_0044 || proc_inst_valid !== 1'b1) $display("FAIL slow_redir_hit: got %h/%0b want C0DE0044/1", proc_inst, proc_inst_valid); else n_pass++;
    n_checks++; if (miss_count !== 16'd4) $display("FAIL slow_miss_count: got %0d want 4", miss_count); else n_pass++;
    present(BUS_LOAD, 32'h238);
    n_checks++; if (proc_inst !== 32'hC0DE_0238 || proc_inst_valid !== 1'b1) $display("FAIL slow_line_hit: got %h/%0b want C0DE0238/1", proc_inst, proc_inst_valid); else n_pass++;
  endtask

  task automatic test_invalidate_idle;
    @(posedge clk); #1;
    proc_command = BUS_LOAD;
    proc_addr    = 32'h44;
    invalidate   = 1'b1;
    @(negedge clk);
    n_checks++; if (proc_inst_valid !== 1'b1) $display("FAIL inv_idle_same_cycle: got %0b want 1", proc_inst_valid); else n_pass++;
    @(posedge clk); #1;
    invalidate = 1'b0;
    proc_addr  = 32'h238;
    @(negedge clk);
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL inv_idle_238: got %0b want 0", proc_inst_valid); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    n_checks++; if (proc_inst !== 32'hC0DE_0238 || proc_inst_valid !== 1'b1) $display("FAIL inv_idle_refill238: got %h/%0b want C0DE0238/1", proc_inst, proc_inst_valid); else n_pass++;
    present(BUS_LOAD, 32'h40);
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL inv_idle_40: got %0b want 0", proc_inst_valid); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    n_checks++; if (miss_count !== 16'd6) $display("FAIL inv_idle_miss_count: got %0d want 6", miss_count); else n_pass++;
  endtask

  task automatic test_invalidate_fill;
    present(BUS_LOAD, 32'h300);
    fill_run(1, 3, 0, 32'h0);
    n_checks++; if (ack_addrs.size() !== 4) $display("FAIL inv_fill_acks: got %0d want 4", ack_addrs.size()); else n_pass++;
    n_checks++; if (fill_cycles !== 4) $display("FAIL inv_fill_cycles: got %0d want 4", fill_cycles); else n_pass++;
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL inv_fill_aborted: got %0b want 0", proc_inst_valid); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    n_checks++; if (first_mc !== 16'd8) $display("FAIL inv_fill_miss_count: got %0d want 8", first_mc); else n_pass++;
    n_checks++; if (proc_inst !== 32'hC0DE_0300 || proc_inst_valid !== 1'b1) $display("FAIL inv_fill_refill_hit: got %h/%0b want C0DE0300/1", proc_inst, proc_inst_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_fill;
    present(BUS_LOAD, 32'h504);
    repeat (2) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1;
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rstfill_pre_req: got %0b want 1", mem_req); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rstfill_async_req: got %0b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL rstfill_async_addr: got %h want 00000000", mem_addr); else n_pass++;
    proc_command = BUS_NONE;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (miss_count !== 16'd0) $display("FAIL rstfill_miss_count: got %0d want 0", miss_count); else n_pass++;
    present(BUS_LOAD, 32'h504);
    n_checks++; if (proc_inst_valid !== 1'b0) $display("FAIL rstfill_partial_miss: got %0b want 0", proc_inst_valid); else n_pass++;
    fill_run(1, 0, 0, 32'h0);
    n_checks++; if (first_mc !== 16'd1) $display("FAIL rstfill_restart_count: got %0d want 1", first_mc); else n_pass++;
    n_checks++; if (proc_inst !== 32'hC0DE_0504 || proc_inst_valid !== 1'b1) $display("FAIL rstfill_hit: got %h/%0b want C0DE0504/1", proc_inst, proc_inst_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_seq_hits();
    test_conflict();
    test_slow_ack();
    test_invalidate_idle();
    test_invalidate_fill();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
